// File: rtl/his_equ_map_pkg.sv
// Shared widths, depths and writer FSM encoding for the histogram-equalisation mapper.
package his_equ_map_pkg;

    localparam int GRAY_W    = 8;
    localparam int ACC_W     = 20;
    localparam int LUT_DEPTH = 256;
    localparam int MAP_LAT   = 2;
    localparam int ADDR_W    = $clog2(LUT_DEPTH) + 1;   // bank bit + gray level

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2
    } wr_state_t;

endpackage

// File: rtl/his_equ_map_if.sv
// Bundle of the cumulative-histogram stream, the live video stream and the mapped output.
interface his_equ_map_if;
    import his_equ_map_pkg::*;

    logic [GRAY_W-1:0] pixel_level;
    logic [ACC_W-1:0]  pixel_level_acc_num;
    logic              pixel_level_valid;
    logic              img_vsync;
    logic              img_href;
    logic [GRAY_W-1:0] img_gray;
    logic              post_vsync;
    logic              post_href;
    logic [GRAY_W-1:0] post_gray;
    logic              lut_ready;
    logic              lut_err;

    // Upstream side: statistics stage + video source, and the consumer of the result.
    modport master (
        output pixel_level, pixel_level_acc_num, pixel_level_valid,
        output img_vsync, img_href, img_gray,
        input  post_vsync, post_href, post_gray, lut_ready, lut_err
    );

    // Mapper side.
    modport slave (
        input  pixel_level, pixel_level_acc_num, pixel_level_valid,
        input  img_vsync, img_href, img_gray,
        output post_vsync, post_href, post_gray, lut_ready, lut_err
    );

endinterface

// File: rtl/his_lut_dpram.sv
// Two-bank LUT storage: one write port, one registered read port, address = {bank, gray}.
module his_lut_dpram
    import his_equ_map_pkg::*;
(
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [GRAY_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [GRAY_W-1:0] rd_data
);

    logic [GRAY_W-1:0] mem [2*LUT_DEPTH];

    // Write port and registered read port; no reset so the array maps onto block RAM.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/his_equ_map.sv
// Histogram-equalisation mapper: builds a LUT from the cumulative histogram of one frame
// into the inactive bank, swaps banks on the next vsync rise and remaps live pixels.
module his_equ_map
    import his_equ_map_pkg::*;
#(
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480,
    parameter int SCALE_SH   = 24
)
(
    input  logic          clk,
    input  logic          rst_n,
    his_equ_map_if.slave  bus
);

    localparam int          PIX_TOTAL   = IMG_WIDTH * IMG_HEIGHT;
    localparam int          PROD_W      = ACC_W + 32;
    localparam logic [63:0] SCALE_MUL_W = ((64'd255 << SCALE_SH) + 64'(PIX_TOTAL / 2))
                                          / 64'(PIX_TOTAL);
    localparam logic [31:0] SCALE_MUL   = SCALE_MUL_W[31:0];

    // Round-half-up the fixed-point product back to a gray level and clamp at 255.
    function automatic logic [GRAY_W-1:0] round_sat(input logic [PROD_W-1:0] prod);
        logic [PROD_W:0] sum;
        logic [PROD_W:0] q;
        sum = {1'b0, prod} + ((PROD_W + 1)'(1) << (SCALE_SH - 1));
        q   = sum >> SCALE_SH;
        if (q > (PROD_W + 1)'(255)) begin
            return {GRAY_W{1'b1}};
        end
        return q[GRAY_W-1:0];
    endfunction

    wr_state_t         state, state_nxt;
    logic [GRAY_W-1:0] exp_level, exp_level_nxt;
    logic              accept, start, last, err;

    logic              vld_p0, vld_p1, vld_p2;
    logic              last_p0, last_p1, last_p2;
    logic [GRAY_W-1:0] lvl_p0, lvl_p1, lvl_p2;
    logic [ACC_W-1:0]  acc_p0;
    logic [PROD_W-1:0] prod_p1;
    logic [GRAY_W-1:0] v_p2;

    logic               active, pending, ready, err_pulse, swap, retire;
    logic [MAP_LAT-1:0] vsync_sr, href_sr;
    logic               use_lut_d1;
    logic [GRAY_W-1:0]  gray_d1, lut_q, map_gray;

    // Writer FSM state and expected-level register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            exp_level <= '0;
        end else begin
            state     <= state_nxt;
            exp_level <= exp_level_nxt;
        end
    end

    // Writer FSM: accept an in-order 0..255 burst, flag gaps and out-of-order beats.
    always_comb begin
        state_nxt     = state;
        exp_level_nxt = exp_level;
        accept        = 1'b0;
        start         = 1'b0;
        last          = 1'b0;
        err           = 1'b0;
        case (state)
            ST_IDLE: begin
                if (bus.pixel_level_valid && bus.pixel_level == '0) begin
                    accept        = 1'b1;
                    start         = 1'b1;
                    exp_level_nxt = GRAY_W'(1);
                    state_nxt     = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (!bus.pixel_level_valid || bus.pixel_level != exp_level) begin
                    err       = 1'b1;
                    state_nxt = ST_IDLE;
                end else begin
                    accept        = 1'b1;
                    exp_level_nxt = exp_level + GRAY_W'(1);
                    if (bus.pixel_level == {GRAY_W{1'b1}}) begin
                        last      = 1'b1;
                        state_nxt = ST_DONE;
                    end
                end
            end
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Build pipeline control: a new table start kills any in-flight completion marker of an
    // older table so that only the newest complete table can raise swap_pending.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p0  <= 1'b0;
            vld_p1  <= 1'b0;
            vld_p2  <= 1'b0;
            last_p0 <= 1'b0;
            last_p1 <= 1'b0;
            last_p2 <= 1'b0;
        end else begin
            // S0: accepted beat captured
            vld_p0  <= accept;
            last_p0 <= last;
            // S1: product
            vld_p1  <= vld_p0;
            last_p1 <= last_p0 & ~start;
            // S2: rounded/saturated value, written to the inactive bank
            vld_p2  <= vld_p1;
            last_p2 <= last_p1 & ~start;
        end
    end

    // Build pipeline datapath: capture, scale by the reciprocal, round and saturate.
    always_ff @(posedge clk) begin
        // S0: accepted beat captured
        lvl_p0  <= bus.pixel_level;
        acc_p0  <= bus.pixel_level_acc_num;
        // S1: product
        lvl_p1  <= lvl_p0;
        prod_p1 <= PROD_W'(acc_p0) * PROD_W'(SCALE_MUL);
        // S2: rounded/saturated value, written to the inactive bank
        lvl_p2  <= lvl_p1;
        v_p2    <= round_sat(prod_p1);
    end

    assign retire = vld_p2 & last_p2;
    assign swap   = bus.img_vsync & ~vsync_sr[0] & pending;

    // Bank swap control: swap only on a vsync rise with a finished table waiting.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active    <= 1'b0;
            pending   <= 1'b0;
            ready     <= 1'b0;
            err_pulse <= 1'b0;
        end else begin
            err_pulse <= err;
            if (swap) begin
                active <= ~active;
                ready  <= 1'b1;
            end
            if (start) begin
                pending <= 1'b0;
            end else if (retire) begin
                pending <= 1'b1;
            end else if (swap) begin
                pending <= 1'b0;
            end
        end
    end

    his_lut_dpram u_lut (
        .clk     (clk),
        .wr_en   (vld_p2),
        .wr_addr ({~active, lvl_p2}),
        .wr_data (v_p2),
        .rd_addr ({active, bus.img_gray}),
        .rd_data (lut_q)
    );

    // Sync delay line and output stage of the mapping path.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vsync_sr   <= '0;
            href_sr    <= '0;
            use_lut_d1 <= 1'b0;
            map_gray   <= '0;
        end else begin
            vsync_sr   <= {vsync_sr[MAP_LAT-2:0], bus.img_vsync};
            href_sr    <= {href_sr[MAP_LAT-2:0], bus.img_href};
            use_lut_d1 <= ready;
            map_gray   <= href_sr[0] ? (use_lut_d1 ? lut_q : gray_d1) : '0;
        end
    end

    // Pass-through copy of the pixel, aligned with the RAM read.
    always_ff @(posedge clk) begin
        gray_d1 <= bus.img_gray;
    end

    assign bus.post_vsync = vsync_sr[MAP_LAT-1];
    assign bus.post_href  = href_sr[MAP_LAT-1];
    assign bus.post_gray  = map_gray;
    assign bus.lut_ready  = ready;
    assign bus.lut_err    = err_pulse;

endmodule

// File: tb/tb_his_equ_map.sv
// Directed bench for his_equ_map on a 4x4 image (PIX_TOTAL=16).
module tb_his_equ_map;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   err_cnt = 0;
    int   e0;

    always #5 clk = ~clk;

    his_equ_map_if bus();

    his_equ_map #(.IMG_WIDTH(4), .IMG_HEIGHT(4), .SCALE_SH(24)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always @(posedge clk) begin
        if (bus.lut_err) err_cnt <= err_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic [19:0] acc_of(input int mode, input int g);
        case (mode)
            0:       return (g < 100) ? 20'd0 : 20'd16;
            1:       return (g < 200) ? 20'd8 : 20'd16;
            default: return (g < 50)  ? 20'd4 : 20'd16;
        endcase
    endfunction

    // Stream levels 0..stop_after, leaving out skip_at, then drop valid.
    task automatic send_table(input int mode, input int stop_after, input int skip_at);
        for (int g = 0; g <= stop_after; g++) begin
            if (g != skip_at) begin
                step(1);
                bus.pixel_level_valid   = 1'b1;
                bus.pixel_level         = 8'(g);
                bus.pixel_level_acc_num = acc_of(mode, g);
            end
        end
        step(1);
        bus.pixel_level_valid = 1'b0;
    endtask

    task automatic map_px(input string tag, input logic [7:0] g, input logic [7:0] exp);
        step(1);
        bus.img_href = 1'b1;
        bus.img_gray = g;
        step(1);
        bus.img_href = 1'b0;
        bus.img_gray = 8'd0;
        chk({tag, "_lat1"}, 32'(bus.post_href), 32'd0);
        step(1);
        chk({tag, "_href"}, 32'(bus.post_href), 32'd1);
        chk(tag, 32'(bus.post_gray), 32'(exp));
        step(1);
        chk({tag, "_blank"}, 32'(bus.post_gray), 32'd0);
    endtask

    task automatic vsync_pulse();
        step(1);
        bus.img_vsync = 1'b1;
        step(1);
        chk("vs_lat1", 32'(bus.post_vsync), 32'd0);
        step(1);
        chk("vs_lat2", 32'(bus.post_vsync), 32'd1);
        bus.img_vsync = 1'b0;
        step(2);
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_vs"},    32'(bus.post_vsync), 32'd0);
        chk({tag, "_href"},  32'(bus.post_href),  32'd0);
        chk({tag, "_gray"},  32'(bus.post_gray),  32'd0);
        chk({tag, "_ready"}, 32'(bus.lut_ready),  32'd0);
        chk({tag, "_err"},   32'(bus.lut_err),    32'd0);
    endtask

    initial begin
        bus.pixel_level         = '0;
        bus.pixel_level_acc_num = '0;
        bus.pixel_level_valid   = 1'b0;
        bus.img_vsync           = 1'b0;
        bus.img_href            = 1'b0;
        bus.img_gray            = '0;

        // Reset and pass-through before any table
        step(3);
        chk_outputs_zero("rst");
        rst_n = 1'b1;
        step(2);
        vsync_pulse();
        chk("t1_ready", 32'(bus.lut_ready), 32'd0);
        map_px("t1_pass37", 8'd37, 8'd37);

        // First table: step at level 100
        e0 = err_cnt;
        send_table(0, 255, -1);
        step(6);
        chk("t2_ready_pre", 32'(bus.lut_ready), 32'd0);
        vsync_pulse();
        chk("t2_ready", 32'(bus.lut_ready), 32'd1);
        chk("t2_err", 32'(err_cnt - e0), 32'd0);
        map_px("t2_g100", 8'd100, 8'd255);
        map_px("t2_g50",  8'd50,  8'd0);
        map_px("t2_g255", 8'd255, 8'd255);

        // Second table only applies after the next vsync rise
        send_table(1, 255, -1);
        step(6);
        map_px("t3_g0_old", 8'd0, 8'd0);
        vsync_pulse();
        map_px("t3_g0",   8'd0,   8'd128);
        map_px("t3_g199", 8'd199, 8'd128);
        map_px("t3_g200", 8'd200, 8'd255);

        // Aborted load: valid drops after level 99
        e0 = err_cnt;
        send_table(0, 99, -1);
        step(4);
        chk("t4_err", 32'(err_cnt - e0), 32'd1);
        vsync_pulse();
        map_px("t4_g0_kept", 8'd0, 8'd128);

        // Out-of-order load (level 4 missing); later beats in IDLE are ignored
        e0 = err_cnt;
        send_table(0, 255, 4);
        step(4);
        chk("t5_err", 32'(err_cnt - e0), 32'd1);
        vsync_pulse();
        map_px("t5_g0_kept", 8'd0, 8'd128);
        e0 = err_cnt;
        send_table(0, 255, -1);
        step(6);
        chk("t5_err_ok", 32'(err_cnt - e0), 32'd0);
        vsync_pulse();
        map_px("t5_g0",   8'd0,   8'd0);
        map_px("t5_g120", 8'd120, 8'd255);

        // Two tables back to back before one vsync: the newer one wins
        send_table(0, 255, -1);
        send_table(1, 255, -1);
        step(6);
        vsync_pulse();
        map_px("t5b_g0", 8'd0, 8'd128);

        // Reset in the middle of a load, during an active line
        bus.img_href = 1'b1;
        bus.img_gray = 8'd77;
        send_table(2, 40, -1);
        bus.pixel_level_valid = 1'b1;
        rst_n = 1'b0;
        #1;
        chk_outputs_zero("t6_rst");
        bus.pixel_level_valid = 1'b0;
        bus.img_href = 1'b0;
        bus.img_gray = 8'd0;
        step(2);
        rst_n = 1'b1;
        step(2);
        map_px("t6_pass77", 8'd77, 8'd77);
        chk("t6_ready0", 32'(bus.lut_ready), 32'd0);
        e0 = err_cnt;
        send_table(2, 255, -1);
        step(6);
        vsync_pulse();
        chk("t6_ready", 32'(bus.lut_ready), 32'd1);
        chk("t6_err", 32'(err_cnt - e0), 32'd0);
        map_px("t6_g10", 8'd10, 8'd64);
        map_px("t6_g60", 8'd60, 8'd255);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
